// File: rtl/fconv_rr_arbiter.sv
// Round-robin arbiter sharing one int32 -> IEEE-754 single converter among NREQ requesters.
// Optional macro FCONV_ARB_PERF_EN adds handshake/stall performance counters.
`timescale 1ns/1ps
module fconv_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 res_valid,
  output logic [31:0]          res_data,
  output logic [IDW-1:0]       res_id,
  input  logic                 res_ready,
  output logic                 busy
`ifdef FCONV_ARB_PERF_EN
  ,
  output logic [31:0]          perf_conv,
  output logic [31:0]          perf_stall
`endif
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t           state, state_nxt;
  logic [IDW-1:0]   rr_ptr, id_reg, gnt_idx;
  logic [31:0]      op_reg, gnt_data, conv_out;
  logic [NREQ-1:0]  gnt_vec;
  logic             gnt_found;

  logic             conv_sign, conv_rnd;
  logic [31:0]      conv_mag, conv_norm;
  logic [4:0]       conv_msb;
  logic [7:0]       conv_exp;

  // Offset k walks rr_ptr+1 .. rr_ptr+NREQ; the second term handles the modulo wrap.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_data  = '0;
    gnt_vec   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!gnt_found && req_valid[i] &&
            ((int'(rr_ptr) + k == i) || (int'(rr_ptr) + k == i + NREQ))) begin
          gnt_found  = 1'b1;
          gnt_idx    = IDW'(i);
          gnt_data   = req_data[32*i +: 32];
          gnt_vec[i] = 1'b1;
        end
      end
    end
  end

  // Converter: normalise magnitude so the leading one sits at bit 31, round to nearest even.
  always_comb begin
    conv_sign = op_reg[31];
    conv_mag  = conv_sign ? (~op_reg + 32'd1) : op_reg;
    conv_msb  = '0;
    for (int b = 0; b < 32; b++) begin
      if (conv_mag[b]) conv_msb = 5'(b);
    end
    conv_norm = conv_mag << (5'd31 - conv_msb);
    conv_exp  = 8'd127 + {3'b000, conv_msb};
    conv_rnd  = conv_norm[7] & ((|conv_norm[6:0]) | conv_norm[8]);
    // Mantissa carry out of rounding ripples into the exponent field on purpose.
    conv_out  = conv_norm[31] ? {conv_sign, {conv_exp, conv_norm[30:8]} + 31'(conv_rnd)} : 32'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (gnt_found) begin
          req_ready = gnt_vec;
          state_nxt = CONV;
        end
      end
      CONV:    state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= IDW'(NREQ - 1);
      op_reg   <= '0;
      id_reg   <= '0;
      res_data <= '0;
      res_id   <= '0;
    end else begin
      if (state == IDLE && gnt_found) begin
        op_reg <= gnt_data;
        id_reg <= gnt_idx;
        rr_ptr <= gnt_idx;
      end
      if (state == CONV) begin
        res_data <= conv_out;
        res_id   <= id_reg;
      end
    end
  end

  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);

`ifdef FCONV_ARB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_conv  <= '0;
      perf_stall <= '0;
    end else if (state == DONE) begin
      if (res_ready && perf_conv != 32'hFFFF_FFFF)   perf_conv  <= perf_conv + 32'd1;
      if (!res_ready && perf_stall != 32'hFFFF_FFFF) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fconv_rr_arbiter.sv
// Bench for fconv_rr_arbiter: transaction-level model checked every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_fconv_rr_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 3;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ-1:0]     req_valid = '0;
  logic [31:0]         opd [NREQ];
  logic [32*NREQ-1:0]  req_data;
  logic [NREQ-1:0]     req_ready;
  logic                res_valid;
  logic [31:0]         res_data;
  logic [IDW-1:0]      res_id;
  logic                res_ready = 1'b1;
  logic                busy;
`ifdef FCONV_ARB_PERF_EN
  logic [31:0]         perf_conv, perf_stall;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int hs_q[$];

  fconv_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .res_valid(res_valid), .res_data(res_data),
    .res_id(res_id), .res_ready(res_ready), .busy(busy)
`ifdef FCONV_ARB_PERF_EN
    , .perf_conv(perf_conv), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NREQ; i++) req_data[32*i +: 32] = opd[i];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic expect_true(input string nm, input bit cond);
    n_chk++;
    if (cond) n_pass++;
    else $display("FAIL %s: condition false at %0t", nm, $time);
  endtask

  // Reference conversion via the exact double value, rounded to single precision.
  function automatic logic [31:0] ref_f32(input logic [31:0] x);
    logic [63:0] d;
    logic [22:0] keep;
    logic [7:0]  e8;
    logic        g, st;
    logic [30:0] body;
    if (x == 32'd0) return 32'd0;
    d    = $realtobits(real'($signed(x)));
    keep = d[51:29];
    g    = d[28];
    st   = |d[27:0];
    e8   = 8'(d[62:52] - 11'd896);
    body = {e8, keep} + 31'(g && (st || keep[0]));
    return {d[63], body};
  endfunction

  // Model: stage 0 = free, 1 = converting, 2 = result offered.
  int          m_stage = 0;
  int          m_last  = NREQ - 1;
  int          m_id    = 0;
  logic [31:0] m_op    = '0;
  int          m_conv  = 0;
  int          m_stall = 0;

  function automatic int pick();
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (m_last + k) % NREQ;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    int w;
    logic [NREQ-1:0] exp_rdy;
    expect_true("ready_onehot0", $onehot0(req_ready));
    if (rst) begin
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_busy",      32'(busy), 32'd0);
      chk("rst_res_data",  res_data, 32'd0);
      chk("rst_res_id",    32'(res_id), 32'd0);
`ifdef FCONV_ARB_PERF_EN
      chk("rst_perf_conv",  perf_conv, 32'd0);
      chk("rst_perf_stall", perf_stall, 32'd0);
`endif
      m_stage = 0; m_last = NREQ - 1; m_conv = 0; m_stall = 0;
    end else begin
      w       = (m_stage == 0) ? pick() : -1;
      exp_rdy = (w >= 0) ? NREQ'(1) << w : '0;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("res_valid", 32'(res_valid), 32'(m_stage == 2));
      chk("busy",      32'(busy), 32'(m_stage != 0));
      if (m_stage == 2) begin
        chk("res_data", res_data, ref_f32(m_op));
        chk("res_id",   32'(res_id), 32'(m_id));
      end
`ifdef FCONV_ARB_PERF_EN
      chk("perf_conv",  perf_conv, 32'(m_conv));
      chk("perf_stall", perf_stall, 32'(m_stall));
`endif
      if (res_valid && res_ready) hs_q.push_back(int'(res_id));
      case (m_stage)
        0: if (w >= 0) begin m_stage = 1; m_last = w; m_id = w; m_op = opd[w]; end
        1: m_stage = 2;
        default: begin
          if (res_ready) begin m_stage = 0; m_conv++; end
          else m_stall++;
        end
      endcase
    end
  end

  task automatic wait_grant(input int idx);
    bit ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (req_ready[idx]) begin ok = 1'b1; break; end
    end
    expect_true("grant_wait", ok);
  endtask

  task automatic wait_result(output int cyc);
    bit ok = 1'b0;
    cyc = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      cyc++;
      if (res_valid) begin ok = 1'b1; break; end
    end
    expect_true("result_wait", ok);
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    expect_true("drain_wait", ok);
  endtask

  task automatic do_one(input int idx, input logic [31:0] val, input logic [31:0] exp_word);
    int cyc;
    @(posedge clk); #1;
    res_ready = 1'b1;
    opd[idx] = val;
    req_valid[idx] = 1'b1;
    wait_grant(idx);
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
    wait_result(cyc);
    chk("latency", 32'(cyc), 32'd2);
    chk("lit_res_data", res_data, exp_word);
    chk("lit_res_id", 32'(res_id), 32'(idx));
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int exp_seq [8];
    for (int i = 0; i < NREQ; i++) opd[i] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // single request and sign/zero/rounding values
    do_one(0, 32'h0000_0001, 32'h3F80_0000);
    do_one(2, 32'd5,         32'h40A0_0000);
    do_one(2, 32'hFFFF_FFFE, 32'hC000_0000);
    do_one(2, 32'd0,         32'h0000_0000);
    do_one(1, 32'h7FFF_FFFF, 32'h4F00_0000);
    do_one(1, 32'h8000_0000, 32'hCF00_0000);
    do_one(1, 32'h0100_0003, 32'h4B80_0002);
    do_one(1, 32'h0100_0001, 32'h4B80_0000);

    // all requesters valid after a reset: rotation starts at 0
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    hs_q.delete();
    for (int i = 0; i < NREQ; i++) opd[i] = 32'(i * 16 + 1);
    req_valid = '1;
    res_ready = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (hs_q.size() >= 8) break;
    end
    @(posedge clk); #1 req_valid = '0;
    expect_true("rotation_count", hs_q.size() >= 8);
    exp_seq = '{0, 1, 2, 3, 0, 1, 2, 3};
    for (int i = 0; i < 8 && i < hs_q.size(); i++) chk("rotation_id", 32'(hs_q[i]), 32'(exp_seq[i]));
    drain();

    // backpressure for five DONE cycles with another requester waiting
    @(posedge clk); #1;
    res_ready = 1'b0;
    opd[1] = 32'd100;
    req_valid[1] = 1'b1;
    wait_grant(1);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    opd[0] = 32'd7;
    req_valid[0] = 1'b1;
    wait_result(cyc);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("bp_res_valid", 32'(res_valid), 32'd1);
      chk("bp_res_data", res_data, 32'h42C8_0000);
      chk("bp_res_id", 32'(res_id), 32'd1);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("bp_release_valid", 32'(res_valid), 32'd1);
    @(negedge clk);
    chk("bp_idle_busy", 32'(busy), 32'd0);
`ifdef FCONV_ARB_PERF_EN
    chk("bp_perf_stall", perf_stall, 32'd5);
    chk("bp_perf_conv", perf_conv, 32'd9);
`endif

    // asynchronous reset while converting
    @(posedge clk); #1;
    opd[0] = 32'd9;
    req_valid[0] = 1'b1;
    wait_grant(0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    chk("conv_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_res_valid", 32'(res_valid), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
`ifdef FCONV_ARB_PERF_EN
    chk("async_perf_conv", perf_conv, 32'd0);
`endif
    @(posedge clk); #1 rst = 1'b0;
    do_one(3, 32'hFFFF_FFFF, 32'hBF80_0000);

    // wrap: after requester 3, requester 0 beats requester 3
    @(posedge clk); #1;
    opd[0] = 32'd3;
    opd[3] = 32'd4;
    req_valid[0] = 1'b1;
    req_valid[3] = 1'b1;
    @(negedge clk);
    chk("wrap_grant", 32'(req_ready), 32'b0001);
    @(posedge clk); #1 req_valid = '0;
    wait_result(cyc);
    chk("wrap_res_id", 32'(res_id), 32'd0);
    chk("wrap_res_data", res_data, 32'h4040_0000);
    drain();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
